// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin front end sharing one sequential Booth multiplier
// between NREQ requesters. A winner's operands are captured at grant, then the block
// pulses mul_start, sends multiplicand then multiplier on mul_data, waits for
// mul_done (with a watchdog) and pulses rsp_valid back to the winner.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req, a_in, b_in         per-requester request and operand slices (W bits each)
//   gnt, rsp_valid          one-hot grant / one-cycle response pulse
//   rsp_data, rsp_err       signed 2W product, timeout flag
//   busy                    high in every state except IDLE
//   mul_start, mul_data     start pulse and operand bus to the multiplier
//   mul_done, mul_result    completion flag and product from the multiplier
// All outputs are registered.
module booth_mul_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [2*W-1:0]    rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic              mul_start,
   output logic [W-1:0]      mul_data,
   input  logic              mul_done,
   input  logic [2*W-1:0]    mul_result
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_LDM, S_LDQ, S_WAIT, S_RESP
   } state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [PW-1:0]     win_q, win_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic [CW-1:0]     wd_q, wd_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   vld_q, vld_d;
   logic [2*W-1:0]    data_q, data_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              start_q, start_d;
   logic [W-1:0]      bus_q, bus_d;

   logic [PW-1:0]     pick;
   logic              found;
   logic [NREQ-1:0]   win_oh;

   // Round-robin: first set bit scanning upward from the last winner + 1.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
            found = 1'b1;
            pick  = PW'((int'(ptr_q) + i) % NREQ);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      a_d     = a_q;
      b_d     = b_q;
      wd_d    = wd_q;
      data_d  = data_q;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               win_d   = pick;
               ptr_d   = pick;
               a_d     = a_in[pick*W +: W];
               b_d     = b_in[pick*W +: W];
               state_d = S_START;
            end
         end
         S_START: state_d = S_LDM;
         S_LDM:   state_d = S_LDQ;
         S_LDQ: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done takes precedence over an expiring watchdog
            if (mul_done) begin
               data_d  = mul_result;
               state_d = S_RESP;
            end else if (wd_q == CW'(TIMEOUT - 1)) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               wd_d = wd_q + CW'(1);
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      win_oh  = {{(NREQ-1){1'b0}}, 1'b1} << win_d;
      gnt_d   = (state_d != S_IDLE) ? win_oh : '0;
      vld_d   = (state_d == S_RESP) ? win_oh : '0;
      busy_d  = (state_d != S_IDLE);
      start_d = (state_d == S_START);
      unique case (state_d)
         S_LDM:   bus_d = a_d;
         S_LDQ:   bus_d = b_d;
         default: bus_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= PW'(NREQ - 1);
         win_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         wd_q    <= '0;
         gnt_q   <= '0;
         vld_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         bus_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         a_q     <= a_d;
         b_q     <= b_d;
         wd_q    <= wd_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         bus_q   <= bus_d;
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = vld_q;
   assign rsp_data  = data_q;
   assign rsp_err   = err_q;
   assign busy      = busy_q;
   assign mul_start = start_q;
   assign mul_data  = bus_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed bench for booth_mul_arbiter with a
// behavioural multiplier of programmable done latency.
module tb_booth_mul_arbiter;

   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] a_in, b_in;
   logic [3:0]  gnt, rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err, busy, mul_start;
   logic [7:0]  mul_data;
   logic        mul_done;
   logic [15:0] mul_result;

   int checks = 0;
   int errors = 0;

   int   lat = 8;
   bit   hang = 1'b0;
   logic extra_done = 1'b0;
   int   ph = 0, cnt = 0;
   logic signed [7:0]  ma, mb;
   logic signed [15:0] prod;
   logic        mdone = 1'b0;
   logic [15:0] mres = '0;

   booth_mul_arbiter #(.NREQ(4), .W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_err(rsp_err), .busy(busy), .mul_start(mul_start),
      .mul_data(mul_data), .mul_done(mul_done), .mul_result(mul_result)
   );

   always #5 clk = ~clk;

   assign mul_done   = mdone | extra_done;
   assign mul_result = mres;

   // behavioural multiplier: start, two operand beats, done after lat cycles
   always @(negedge clk) begin
      mdone = 1'b0;
      if (mul_start) begin
         ph = 1;
      end else if (ph == 1) begin
         ma = mul_data; ph = 2;
      end else if (ph == 2) begin
         mb = mul_data; ph = 3; cnt = 0;
      end else if (ph == 3) begin
         cnt++;
         if (!hang && cnt == lat) begin
            prod = ma * mb;
            mres = prod;
            mdone = 1'b1;
            ph = 0;
         end
      end
   end

   task automatic wait_rsp(output int n, output bit ok);
      n = 0; ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk); n++;
         if (rsp_valid !== 4'b0) ok = 1'b1;
      end
   endtask

   task automatic start_req(input int idx, input logic [7:0] a,
                            input logic [7:0] b);
      a_in[idx*8 +: 8] = a;
      b_in[idx*8 +: 8] = b;
      req[idx] = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_data} !== 35'b0) begin
         errors++;
         $display("FAIL reset_outputs got %h want 0",
            {gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_data});
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || gnt !== 4'b0) begin
         errors++;
         $display("FAIL reset_idle busy %b gnt %b want 0 0", busy, gnt);
      end
   endtask

   task automatic test_single();
      int n; bit ok;
      lat = 8;
      start_req(0, 8'd5, 8'd8);
      @(negedge clk);
      checks++;
      if (mul_start !== 1'b1 || gnt !== 4'b0001 || busy !== 1'b1 || mul_data !== 8'h00) begin
         errors++;
         $display("FAIL single_start start %b gnt %b busy %b data %h want 1 0001 1 00",
            mul_start, gnt, busy, mul_data);
      end
      @(negedge clk);
      checks++;
      if (mul_start !== 1'b0 || mul_data !== 8'd5) begin
         errors++;
         $display("FAIL single_ldm start %b data %h want 0 05", mul_start, mul_data);
      end
      @(negedge clk);
      checks++;
      if (mul_data !== 8'd8) begin
         errors++;
         $display("FAIL single_ldq data %h want 08", mul_data);
      end
      wait_rsp(n, ok);
      checks++;
      if (!ok || n != 9 || rsp_valid !== 4'b0001 || rsp_data !== 16'h0028 ||
          rsp_err !== 1'b0 || gnt !== 4'b0001) begin
         errors++;
         $display("FAIL single_rsp ok %0d n %0d vld %b data %h err %b gnt %b want 1 9 0001 0028 0 0001",
            ok, n, rsp_valid, rsp_data, rsp_err, gnt);
      end
      req = '0;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0 || rsp_valid !== 4'b0 || busy !== 1'b0 || rsp_data !== 16'h0028) begin
         errors++;
         $display("FAIL single_after gnt %b vld %b busy %b data %h want 0 0 0 0028",
            gnt, rsp_valid, busy, rsp_data);
      end
   endtask

   task automatic test_signed();
      logic [7:0]  va [2] = '{8'hFD, 8'h80};
      logic [7:0]  vb [2] = '{8'h07, 8'h80};
      logic [15:0] vp [2] = '{16'hFFEB, 16'h4000};
      int n; bit ok;
      lat = 3;
      for (int k = 0; k < 2; k++) begin
         start_req(2, va[k], vb[k]);
         repeat (3) @(negedge clk);
         wait_rsp(n, ok);
         checks++;
         if (!ok || rsp_valid !== 4'b0100 || rsp_data !== vp[k] || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL signed_%0d ok %0d vld %b data %h err %b want 1 0100 %h 0",
               k, ok, rsp_valid, rsp_data, rsp_err, vp[k]);
         end
         req = '0;
         @(negedge clk);
      end
   endtask

   task automatic test_round_robin();
      int order [5] = '{0, 1, 2, 3, 0};
      int n; bit ok;
      logic [3:0] eg;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      lat = 2;
      a_in = {8'd4, 8'd3, 8'd2, 8'd1};
      b_in = {4{8'd3}};
      req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         eg = 4'b0001 << order[k];
         ok = 1'b0;
         for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (gnt !== 4'b0) ok = 1'b1;
         end
         checks++;
         if (!ok || gnt !== eg || !$onehot(gnt)) begin
            errors++;
            $display("FAIL rr_gnt_%0d ok %0d gnt %b want %b", k, ok, gnt, eg);
         end
         wait_rsp(n, ok);
         checks++;
         if (!ok || rsp_valid !== eg || gnt !== eg ||
             rsp_data !== 16'(3 * (order[k] + 1))) begin
            errors++;
            $display("FAIL rr_rsp_%0d ok %0d vld %b gnt %b data %h want %b %b %h",
               k, ok, rsp_valid, gnt, rsp_data, eg, eg, 16'(3 * (order[k] + 1)));
         end
         if (k == 4) req = '0;
         @(negedge clk);
         checks++;
         if (gnt !== 4'b0) begin
            errors++;
            $display("FAIL rr_gap_%0d gnt %b want 0000", k, gnt);
         end
      end
   endtask

   task automatic test_timeout();
      int n; bit ok;
      hang = 1'b1;
      start_req(1, 8'h11, 8'h22);
      repeat (3) @(negedge clk);
      wait_rsp(n, ok);
      checks++;
      if (!ok || n != TO + 1 || rsp_valid !== 4'b0010 || rsp_err !== 1'b1 ||
          rsp_data !== 16'h0000) begin
         errors++;
         $display("FAIL timeout_rsp ok %0d n %0d vld %b err %b data %h want 1 %0d 0010 1 0000",
            ok, n, rsp_valid, rsp_err, rsp_data, TO + 1);
      end
      req = '0;
      @(negedge clk);
      checks++;
      if (rsp_err !== 1'b0 || rsp_valid !== 4'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_after err %b vld %b busy %b want 0 0 0", rsp_err, rsp_valid, busy);
      end
      hang = 1'b0;
      lat = TO;
      start_req(1, 8'd6, 8'hFE);
      repeat (3) @(negedge clk);
      wait_rsp(n, ok);
      checks++;
      if (!ok || n != TO + 1 || rsp_valid !== 4'b0010 || rsp_err !== 1'b0 ||
          rsp_data !== 16'hFFF4) begin
         errors++;
         $display("FAIL done_vs_timeout ok %0d n %0d vld %b err %b data %h want 1 %0d 0010 0 fff4",
            ok, n, rsp_valid, rsp_err, rsp_data, TO + 1);
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n; bit ok;
      int bad;
      lat = 20;
      start_req(0, 8'd9, 8'd9);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      req = '0;
      @(negedge clk);
      checks++;
      if ({gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_data} !== 35'b0) begin
         errors++;
         $display("FAIL midreset_outputs got %h want 0",
            {gnt, rsp_valid, rsp_data, rsp_err, busy, mul_start, mul_data});
      end
      rst_n = 1'b1;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (rsp_valid !== 4'b0 || busy !== 1'b0 || mul_start !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midreset_quiet bad_cycles %0d want 0", bad);
      end
      start_req(3, 8'd10, 8'd10);
      repeat (3) @(negedge clk);
      wait_rsp(n, ok);
      checks++;
      if (!ok || n != 21 || rsp_valid !== 4'b1000 || rsp_data !== 16'h0064 ||
          rsp_err !== 1'b0) begin
         errors++;
         $display("FAIL midreset_fresh ok %0d n %0d vld %b data %h err %b want 1 21 1000 0064 0",
            ok, n, rsp_valid, rsp_data, rsp_err);
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_idle_done();
      int n; bit ok;
      extra_done = 1'b1;
      @(negedge clk);
      extra_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_done vld %b busy %b want 0000 0", rsp_valid, busy);
      end
      lat = 5;
      start_req(1, 8'd4, 8'hFB);
      @(negedge clk);
      a_in[15:8] = 8'd99;
      b_in[15:8] = 8'd99;
      extra_done = 1'b1;
      checks++;
      if (gnt !== 4'b0010) begin
         errors++;
         $display("FAIL capture_gnt gnt %b want 0010", gnt);
      end
      @(negedge clk);
      extra_done = 1'b0;
      checks++;
      if (mul_data !== 8'd4) begin
         errors++;
         $display("FAIL capture_a data %h want 04", mul_data);
      end
      @(negedge clk);
      checks++;
      if (mul_data !== 8'hFB) begin
         errors++;
         $display("FAIL capture_b data %h want fb", mul_data);
      end
      wait_rsp(n, ok);
      checks++;
      if (!ok || n != 6 || rsp_valid !== 4'b0010 || rsp_data !== 16'hFFEC) begin
         errors++;
         $display("FAIL capture_rsp ok %0d n %0d vld %b data %h want 1 6 0010 ffec",
            ok, n, rsp_valid, rsp_data);
      end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_single();
      test_signed();
      test_round_robin();
      test_timeout();
      test_reset_mid();
      test_idle_done();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
